// File: rtl/kb_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// kb_event_arbiter_pkg
// Shared definitions for the keyboard event arbiter: event-code prefixes,
// the overflow marker code, source indices and the encoder code builder.
// No ports.
// ---------------------------------------------------------------------------
package kb_event_arbiter_pkg;

    localparam logic [1:0] EVT_PRESS    = 2'b01;
    localparam logic [1:0] EVT_RELEASE  = 2'b10;
    localparam logic [1:0] EVT_ENC      = 2'b11;
    localparam logic [7:0] EVT_OVF_MARK = 8'hFF;

    localparam int NUM_SRC  = 5;
    localparam int SRC_KEY  = 0;
    localparam int SRC_ENC0 = 1;

    // Encoder event: {11, 000, encoder number, direction(1=CW)} -> 8'hC0..8'hC7
    function automatic logic [7:0] encCode(input logic [1:0] encNum, input logic dir);
        return {EVT_ENC, 3'b000, encNum, dir};
    endfunction

endpackage

// File: rtl/kb_evt_fifo.sv
// ---------------------------------------------------------------------------
// kb_evt_fifo
// First-word fall-through FIFO. The head entry is visible on dout whenever
// the FIFO is non-empty; dout reads zero when empty.
// Ports:
//   clk, rst        clock, async active-high reset
//   wr_en, din      push request and data (ignored when full unless popping)
//   rd_en           pop request (ignored when empty)
//   dout            head entry, zero when empty
//   level           occupancy 0..DEPTH
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module kb_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign empty  = (level == '0);
    assign full   = (level == (AW+1)'(DEPTH));
    assign doPop  = rd_en && !empty;
    // A pop at the same edge frees the slot, so a full FIFO still accepts the write.
    assign doPush = wr_en && (!full || doPop);
    assign dout   = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/kb_event_arbiter.sv
// ---------------------------------------------------------------------------
// kb_event_arbiter
// Merges one key-scan source and four encoder step sources into a single
// ordered 8-bit event stream, buffered in a FWFT FIFO with valid/ack pop.
// Each source has a one-entry pending register; a round-robin scan grants
// at most one source per cycle into the FIFO.
// Build option: KB_EVT_OVF_MARK_EN -- after a dropped event, the next FIFO
// write slot carries 8'hFF as a loss marker.
// Ports:
//   clk, rst              clock, async active-high reset
//   key_evt_rdy, key_evt  key event strobe and code
//   enc_step, enc_dir     per-encoder step strobe and direction (1=CW)
//   evt_ack               pop head event (ignored while evt_valid=0)
//   ovf_clr               clear sticky overflow flag
//   evt_valid, evt_code   head event valid / code (8'h00 when empty)
//   evt_level             FIFO occupancy
//   evt_ovf               sticky flag: an event was lost
// ---------------------------------------------------------------------------
module kb_event_arbiter
    import kb_event_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_evt_rdy,
    input  logic [7:0]         key_evt,
    input  logic [3:0]         enc_step,
    input  logic [3:0]         enc_dir,
    input  logic               evt_ack,
    input  logic               ovf_clr,
    output logic               evt_valid,
    output logic [7:0]         evt_code,
    output logic [FIFO_AW:0]   evt_level,
    output logic               evt_ovf
);

    logic [NUM_SRC-1:0]      srcStrobe;
    logic [NUM_SRC-1:0][7:0] srcCode;
    logic [NUM_SRC-1:0]      pendValid;
    logic [NUM_SRC-1:0][7:0] pendCode;
    logic [NUM_SRC-1:0]      grantVec;
    logic [NUM_SRC-1:0]      dropVec;
    logic [2:0]              rrPtr;
    logic [2:0]              grantIdx;
    logic [2:0]              scanIdx;
    logic                    grantHit;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic                    popNow;
    logic                    canWrite;
    logic                    grantWrite;
    logic                    markWrite;
    logic                    fifoWr;
    logic [7:0]              fifoDin;

    always_comb begin
        srcCode          = '0;
        srcCode[SRC_KEY] = key_evt;
        for (int j = 0; j < 4; j++) begin
            srcCode[SRC_ENC0+j] = encCode(2'(j), enc_dir[j]);
        end
    end
    assign srcStrobe = {enc_step, key_evt_rdy};

    assign popNow   = evt_ack && !fifoEmpty;
    assign canWrite = !fifoFull || popNow;

    // Round-robin: start one past the last granted source and wrap through all five.
    always_comb begin
        grantHit = 1'b0;
        grantIdx = rrPtr;
        scanIdx  = rrPtr;
        for (int k = 1; k <= NUM_SRC; k++) begin
            scanIdx = 3'((int'(rrPtr) + k) % NUM_SRC);
            if (!grantHit && pendValid[scanIdx]) begin
                grantHit = 1'b1;
                grantIdx = scanIdx;
            end
        end
    end

`ifdef KB_EVT_OVF_MARK_EN
    logic markArmed;

    assign markWrite = markArmed && canWrite;

    // A drop in the same cycle as the marker write is covered by that marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            markArmed <= 1'b0;
        end else if (markWrite) begin
            markArmed <= 1'b0;
        end else if (|dropVec) begin
            markArmed <= 1'b1;
        end
    end
`else
    assign markWrite = 1'b0;
`endif

    assign grantWrite = canWrite && grantHit && !markWrite;
    assign grantVec   = grantWrite ? (NUM_SRC'(1) << grantIdx) : '0;
    // A source granted this edge frees its pending slot, so a new strobe replaces it.
    assign dropVec    = srcStrobe & pendValid & ~grantVec;
    assign fifoWr     = grantWrite || markWrite;
    assign fifoDin    = markWrite ? EVT_OVF_MARK : pendCode[grantIdx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendValid <= '0;
            pendCode  <= '0;
            rrPtr     <= 3'(NUM_SRC - 1);
            evt_ovf   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (srcStrobe[i] && !dropVec[i]) begin
                    pendValid[i] <= 1'b1;
                    pendCode[i]  <= srcCode[i];
                end else if (grantVec[i]) begin
                    pendValid[i] <= 1'b0;
                end
            end
            if (grantWrite) begin
                rrPtr <= grantIdx;
            end
            if (|dropVec) begin
                evt_ovf <= 1'b1;
            end else if (ovf_clr) begin
                evt_ovf <= 1'b0;
            end
        end
    end

    kb_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .DW    (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (fifoWr),
        .rd_en (evt_ack),
        .din   (fifoDin),
        .dout  (evt_code),
        .level (evt_level),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign evt_valid = !fifoEmpty;

endmodule

// File: tb/tb_kb_event_arbiter.sv
module tb_kb_event_arbiter;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_evt_rdy = 1'b0;
    logic [7:0] key_evt = 8'h00;
    logic [3:0] enc_step = 4'h0;
    logic [3:0] enc_dir = 4'h0;
    logic       evt_ack = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic [3:0] evt_level;
    logic       evt_ovf;

    int nChecks = 0;
    int nFails  = 0;

    // reference model state
    logic [7:0] mQ[$];
    bit         mPend[5];
    logic [7:0] mCode[5];
    int         mRr;
    bit         mOvf;
    bit         mArmed;

    kb_event_arbiter #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_evt_rdy (key_evt_rdy),
        .key_evt     (key_evt),
        .enc_step    (enc_step),
        .enc_dir     (enc_dir),
        .evt_ack     (evt_ack),
        .ovf_clr     (ovf_clr),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_level   (evt_level),
        .evt_ovf     (evt_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic modelReset();
        mQ.delete();
        for (int i = 0; i < 5; i++) begin
            mPend[i] = 0;
            mCode[i] = 8'h00;
        end
        mRr    = 4;
        mOvf   = 0;
        mArmed = 0;
    endtask

    // One clock edge of the arbiter, computed from the event rules.
    task automatic modelEdge();
        bit         pop;
        bit         room;
        bit         mark;
        bit         drop;
        int         g;
        bit         stb[5];
        logic [7:0] newc[5];
        logic [7:0] wr;
        pop  = evt_ack && (mQ.size() > 0);
        room = (mQ.size() < DEPTH) || pop;
        mark = 0;
        drop = 0;
        g    = -1;
        wr   = 8'h00;
        stb[0]  = key_evt_rdy;
        newc[0] = key_evt;
        for (int j = 0; j < 4; j++) begin
            stb[j+1]  = enc_step[j];
            newc[j+1] = 8'(8'hC0 + 2 * j + int'(enc_dir[j]));
        end
        if (room) begin
`ifdef KB_EVT_OVF_MARK_EN
            if (mArmed) mark = 1;
`endif
            if (!mark) begin
                for (int k = 1; k <= 5; k++) begin
                    int i;
                    i = (mRr + k) % 5;
                    if (g < 0 && mPend[i]) g = i;
                end
            end
        end
        if (g >= 0) begin
            wr       = mCode[g];
            mPend[g] = 0;
            mRr      = g;
        end
        for (int i = 0; i < 5; i++) begin
            if (stb[i]) begin
                if (mPend[i]) drop = 1;
                else begin
                    mPend[i] = 1;
                    mCode[i] = newc[i];
                end
            end
        end
        if (pop) void'(mQ.pop_front());
        if (mark) mQ.push_back(8'hFF);
        else if (g >= 0) mQ.push_back(wr);
        if (drop) mOvf = 1;
        else if (ovf_clr) mOvf = 0;
        if (mark) mArmed = 0;
        else if (drop) mArmed = 1;
    endtask

    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        key_evt_rdy = 0;
        key_evt     = 8'h00;
        enc_step    = 4'h0;
        enc_dir     = 4'h0;
        evt_ack     = 0;
        ovf_clr     = 0;
    endtask

    task automatic applyReset();
        clearInputs();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        modelReset();
    endtask

    task automatic fillFifo();
        for (int k = 0; k < 8; k++) begin
            key_evt     = 8'(8'h50 + k);
            key_evt_rdy = 1;
            step();
        end
        key_evt_rdy = 0;
        step();
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1;
        @(posedge clk);
        #1;
        modelReset();
        nChecks++;
        if (evt_valid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %0b expected 0", evt_valid); end
        nChecks++;
        if (evt_code !== 8'h00) begin nFails++; $display("FAIL reset_code: got %h expected 00", evt_code); end
        nChecks++;
        if (evt_level !== 4'd0) begin nFails++; $display("FAIL reset_level: got %0d expected 0", evt_level); end
        nChecks++;
        if (evt_ovf !== 1'b0) begin nFails++; $display("FAIL reset_ovf: got %0b expected 0", evt_ovf); end
        rst = 0;
    endtask

    task automatic test_single();
        key_evt     = 8'h45;
        key_evt_rdy = 1;
        step();
        key_evt_rdy = 0;
        nChecks++;
        if (evt_valid !== 1'b0) begin nFails++; $display("FAIL single_early_valid: got %0b expected 0", evt_valid); end
        step();
        nChecks++;
        if (evt_valid !== 1'b1) begin nFails++; $display("FAIL single_valid: got %0b expected 1", evt_valid); end
        nChecks++;
        if (evt_code !== 8'h45) begin nFails++; $display("FAIL single_code: got %h expected 45", evt_code); end
        nChecks++;
        if (evt_level !== 4'd1) begin nFails++; $display("FAIL single_level: got %0d expected 1", evt_level); end
        evt_ack = 1;
        step();
        evt_ack = 0;
        nChecks++;
        if (evt_valid !== 1'b0) begin nFails++; $display("FAIL single_pop_valid: got %0b expected 0", evt_valid); end
        nChecks++;
        if (evt_code !== 8'h00) begin nFails++; $display("FAIL single_pop_code: got %h expected 00", evt_code); end
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp[3];
        exp[0] = 8'h81;
        exp[1] = 8'hC1;
        exp[2] = 8'hC4;
        applyReset();
        key_evt     = 8'h81;
        key_evt_rdy = 1;
        enc_step    = 4'b0101;
        enc_dir     = 4'b0001;
        step();
        clearInputs();
        step();
        step();
        step();
        nChecks++;
        if (evt_level !== 4'd3) begin nFails++; $display("FAIL same_cycle_level: got %0d expected 3", evt_level); end
        for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (evt_code !== exp[k]) begin nFails++; $display("FAIL same_cycle_order[%0d]: got %h expected %h", k, evt_code, exp[k]); end
            evt_ack = 1;
            step();
        end
        evt_ack = 0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        logic [7:0] got[$];
        int         nMark;
        applyReset();
        fillFifo();
        nChecks++;
        if (evt_level !== 4'd8) begin nFails++; $display("FAIL ovf_fill_level: got %0d expected 8", evt_level); end
        key_evt     = 8'h42;
        key_evt_rdy = 1;
        step();
        key_evt     = 8'h43;
        step();
        key_evt_rdy = 0;
        nChecks++;
        if (evt_ovf !== 1'b1) begin nFails++; $display("FAIL ovf_set: got %0b expected 1", evt_ovf); end
        evt_ack = 1;
        step();
        evt_ack = 0;
        nChecks++;
        if (evt_level !== 4'd8) begin nFails++; $display("FAIL ovf_ack_level: got %0d expected 8", evt_level); end
        for (int k = 1; k < 8; k++) exp.push_back(8'(8'h50 + k));
`ifdef KB_EVT_OVF_MARK_EN
        exp.push_back(8'hFF);
`endif
        exp.push_back(8'h42);
        for (int n = 0; n < 20 && evt_valid; n++) begin
            got.push_back(evt_code);
            evt_ack = 1;
            step();
        end
        evt_ack = 0;
        nChecks++;
        if (got.size() != exp.size()) begin nFails++; $display("FAIL ovf_drain_count: got %0d expected %0d", got.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            nChecks++;
            if (got[k] !== exp[k]) begin nFails++; $display("FAIL ovf_drain[%0d]: got %h expected %h", k, got[k], exp[k]); end
        end
        nMark = 0;
        foreach (got[k]) if (got[k] == 8'hFF) nMark++;
`ifdef KB_EVT_OVF_MARK_EN
        nChecks++;
        if (nMark != 1) begin nFails++; $display("FAIL ovf_marker_count: got %0d expected 1", nMark); end
`else
        nChecks++;
        if (nMark != 0) begin nFails++; $display("FAIL ovf_marker_count: got %0d expected 0", nMark); end
`endif
    endtask

    task automatic test_full_wrap();
        logic [7:0] got[$];
        applyReset();
        fillFifo();
        key_evt     = 8'h60;
        key_evt_rdy = 1;
        step();
        for (int k = 0; k < 10; k++) begin
            key_evt     = 8'(8'h61 + k);
            key_evt_rdy = 1;
            evt_ack     = 1;
            got.push_back(evt_code);
            step();
            nChecks++;
            if (evt_level !== 4'd8) begin nFails++; $display("FAIL wrap_level[%0d]: got %0d expected 8", k, evt_level); end
        end
        clearInputs();
        for (int k = 0; k < 10; k++) begin
            logic [7:0] e;
            e = (k < 8) ? 8'(8'h50 + k) : 8'(8'h60 + k - 8);
            nChecks++;
            if (got[k] !== e) begin nFails++; $display("FAIL wrap_order[%0d]: got %h expected %h", k, got[k], e); end
        end
        nChecks++;
        if (evt_code !== 8'h62) begin nFails++; $display("FAIL wrap_head: got %h expected 62", evt_code); end
        nChecks++;
        if (evt_ovf !== 1'b0) begin nFails++; $display("FAIL wrap_no_ovf: got %0b expected 0", evt_ovf); end
    endtask

    task automatic test_ovf_clr();
        // FIFO is full and the key source is still pending from the previous test.
        key_evt     = 8'h70;
        key_evt_rdy = 1;
        step();
        key_evt_rdy = 0;
        nChecks++;
        if (evt_ovf !== 1'b1) begin nFails++; $display("FAIL clr_setup: got %0b expected 1", evt_ovf); end
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        nChecks++;
        if (evt_ovf !== 1'b0) begin nFails++; $display("FAIL clr_alone: got %0b expected 0", evt_ovf); end
        ovf_clr     = 1;
        key_evt     = 8'h71;
        key_evt_rdy = 1;
        step();
        clearInputs();
        nChecks++;
        if (evt_ovf !== 1'b1) begin nFails++; $display("FAIL clr_vs_drop: got %0b expected 1", evt_ovf); end
    endtask

    task automatic randomInputs(input int cyc);
        int ackPct;
        case ((cyc / 200) % 3)
            0:       ackPct = 10;
            1:       ackPct = 50;
            default: ackPct = 90;
        endcase
        key_evt_rdy = ($urandom_range(0, 3) == 0);
        key_evt     = {($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 6'($urandom)};
        for (int j = 0; j < 4; j++) enc_step[j] = ($urandom_range(0, 5) == 0);
        enc_dir = 4'($urandom);
        evt_ack = ($urandom_range(0, 99) < ackPct);
        ovf_clr = ($urandom_range(0, 19) == 0);
    endtask

    task automatic test_random();
        applyReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            randomInputs(cyc);
            step();
            nChecks++;
            if (evt_valid !== (mQ.size() != 0)) begin nFails++; $display("FAIL rand_valid @%0d: got %0b expected %0b", cyc, evt_valid, mQ.size() != 0); end
            nChecks++;
            if (evt_code !== ((mQ.size() != 0) ? mQ[0] : 8'h00)) begin nFails++; $display("FAIL rand_code @%0d: got %h expected %h", cyc, evt_code, (mQ.size() != 0) ? mQ[0] : 8'h00); end
            nChecks++;
            if (evt_level !== 4'(mQ.size())) begin nFails++; $display("FAIL rand_level @%0d: got %0d expected %0d", cyc, evt_level, mQ.size()); end
            nChecks++;
            if (evt_ovf !== mOvf) begin nFails++; $display("FAIL rand_ovf @%0d: got %0b expected %0b", cyc, evt_ovf, mOvf); end
        end
        clearInputs();
    endtask

    task automatic test_reset_mid();
        applyReset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            randomInputs(200);
            step();
        end
        nChecks++;
        if (evt_level !== 4'(mQ.size())) begin nFails++; $display("FAIL mid_pre_level: got %0d expected %0d", evt_level, mQ.size()); end
        rst = 1;
        #1;
        nChecks++;
        if (evt_level !== 4'd0) begin nFails++; $display("FAIL mid_reset_level: got %0d expected 0", evt_level); end
        nChecks++;
        if (evt_valid !== 1'b0) begin nFails++; $display("FAIL mid_reset_valid: got %0b expected 0", evt_valid); end
        nChecks++;
        if (evt_code !== 8'h00) begin nFails++; $display("FAIL mid_reset_code: got %h expected 00", evt_code); end
        clearInputs();
        @(posedge clk);
        #1;
        rst = 0;
        modelReset();
        step();
        step();
        nChecks++;
        if (evt_valid !== 1'b0) begin nFails++; $display("FAIL mid_after_valid: got %0b expected 0", evt_valid); end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_single();
        test_same_cycle();
        test_overflow();
        test_full_wrap();
        test_ovf_clr();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
